// File: rtl/maclaurin_controller_pkg.sv
// Purpose: shared encodings and sizes for the Maclaurin pipeline sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, ring depth, slot/iteration counter widths.
package maclaurin_controller_pkg;

    // Number of registers in the datapath ring (one operand slot per register).
    localparam int RING_DEPTH = 4;
    localparam int SLOT_W     = 2;
    localparam int ITER_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_PAD  = 3'd2,
        ST_ITER = 3'd3,
        ST_OUT  = 3'd4
    } state_e;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(RING_DEPTH - 1);

endpackage

// File: rtl/maclaurin_controller_slot_flags.sv
// Purpose: per-slot valid/error flag file for the 4 operand slots of one batch.
// Latency: writes visible the cycle after wr_en_i; reads are combinational.
// Backpressure: none; the controller decides when to write or clear.
// Ports: clk/rst (sync, active-high), wr_* single-slot write, clr_i clears all
//        slots (wins over a write), rd_idx_i selects the slot driven on rd_*_o.
module maclaurin_controller_slot_flags
    import maclaurin_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [SLOT_W-1:0] wr_idx_i,
    input  logic              wr_vld_i,
    input  logic              wr_err_i,
    input  logic              clr_i,
    input  logic [SLOT_W-1:0] rd_idx_i,
    output logic              rd_vld_o,
    output logic              rd_err_o
);

    logic [RING_DEPTH-1:0] vld_q, vld_d;
    logic [RING_DEPTH-1:0] err_q, err_d;

    always_comb begin
        vld_d = vld_q;
        err_d = err_q;
        if (clr_i) begin
            vld_d = '0;
            err_d = '0;
        end else if (wr_en_i) begin
            vld_d[wr_idx_i] = wr_vld_i;
            err_d[wr_idx_i] = wr_err_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

    assign rd_vld_o = vld_q[rd_idx_i];
    assign rd_err_o = err_q[rd_idx_i];

endmodule

// File: rtl/maclaurin_controller.sv
// Purpose: sequences a 4-slot recirculating Maclaurin datapath: fill, iterate, drain.
// Latency: first result 4*PASSES cycles after slot 0 loads (no stalls), then 1/cycle.
// Backpressure: out_ready low on a valid slot freezes the ring; inputs taken only in IDLE/FILL.
// Ports: in_* operand handshake (in_last closes a batch early), dp_* datapath
//        controls and read-back, out_* result handshake with slot tag and flags,
//        busy high whenever a batch is in flight.
module maclaurin_controller
    import maclaurin_controller_pkg::*;
#(
    parameter int PASSES = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [7:0]  in_x,
    input  logic [2:0]  in_n,
    output logic        dp_src,
    output logic        dp_load,
    output logic [7:0]  dp_x,
    output logic [2:0]  dp_n,
    input  logic [31:0] dp_y,
    input  logic        dp_overflow,
    input  logic        dp_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic [1:0]  out_tag,
    output logic        out_overflow,
    output logic        out_error,
    output logic        busy
);

    // Extra ring trips after the fill pass; the fill itself is the first pass.
    localparam logic [ITER_W-1:0] ITER_LOAD =
        (PASSES > 1) ? ITER_W'(RING_DEPTH * (PASSES - 1) - 1) : '0;
    localparam state_e FILL_EXIT = (PASSES > 1) ? ST_ITER : ST_OUT;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [ITER_W-1:0]   iter_q, iter_d;

    logic                fl_wr_en;
    logic                fl_wr_vld;
    logic                fl_wr_err;
    logic                fl_clr;
    logic                cur_vld;
    logic                cur_err;
    logic                out_adv;

    // In OUT the slot counter doubles as the drain index j.
    maclaurin_controller_slot_flags u_slot_flags (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (fl_wr_en),
        .wr_idx_i (slot_q),
        .wr_vld_i (fl_wr_vld),
        .wr_err_i (fl_wr_err),
        .clr_i    (fl_clr),
        .rd_idx_i (slot_q),
        .rd_vld_o (cur_vld),
        .rd_err_o (cur_err)
    );

    // Bubble slots drain without a handshake; real slots wait for the consumer.
    assign out_adv = !cur_vld || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        iter_d    = iter_q;
        fl_wr_en  = 1'b0;
        fl_wr_vld = 1'b0;
        fl_wr_err = 1'b0;
        fl_clr    = 1'b0;
        case (state_q)
            // IDLE always sits at slot 0, so it shares the FILL accept path.
            ST_IDLE, ST_FILL: begin
                if (in_valid) begin
                    fl_wr_en  = 1'b1;
                    fl_wr_vld = 1'b1;
                    fl_wr_err = dp_error;
                    slot_d    = slot_q + 2'd1;
                    if (slot_q == SLOT_LAST) begin
                        state_d = FILL_EXIT;
                        iter_d  = ITER_LOAD;
                    end else if (in_last) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_PAD: begin
                fl_wr_en = 1'b1;
                slot_d   = slot_q + 2'd1;
                if (slot_q == SLOT_LAST) begin
                    state_d = FILL_EXIT;
                    iter_d  = ITER_LOAD;
                end
            end
            ST_ITER: begin
                if (iter_q == '0) begin
                    state_d = ST_OUT;
                end else begin
                    iter_d = iter_q - 6'd1;
                end
            end
            ST_OUT: begin
                if (out_adv) begin
                    slot_d = slot_q + 2'd1;
                    if (slot_q == SLOT_LAST) begin
                        state_d = ST_IDLE;
                        fl_clr  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        dp_src    = 1'b0;
        dp_load   = 1'b0;
        dp_x      = '0;
        dp_n      = '0;
        out_valid = 1'b0;
        out_error = 1'b0;
        case (state_q)
            ST_IDLE, ST_FILL: begin
                in_ready = 1'b1;
                dp_load  = in_valid;
                // Operand is only forwarded when offered, so an idle bus reads 0.
                if (in_valid) begin
                    dp_x = in_x;
                    dp_n = in_n;
                end
            end
            ST_PAD: begin
                dp_load = 1'b1;
            end
            ST_ITER: begin
                dp_src  = 1'b1;
                dp_load = 1'b1;
            end
            ST_OUT: begin
                dp_src    = 1'b1;
                dp_load   = out_adv;
                out_valid = cur_vld;
                out_error = cur_err;
            end
            default: ;
        endcase
    end

    assign out_tag      = slot_q;
    assign out_y        = dp_y;
    assign out_overflow = dp_overflow;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_maclaurin_controller.sv
module tb_maclaurin_controller;

    typedef struct {
        int          tag;
        logic [31:0] y;
        logic        ovf;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] val;
    } ctrl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_last;
    logic [7:0]  in_x;
    logic [2:0]  in_n;

    // Instance with PASSES = 2
    logic        in_ready2, dp_src2, dp_load2, dp_ovf2, dp_err2;
    logic [7:0]  dp_x2;
    logic [2:0]  dp_n2;
    logic [31:0] dp_y2, out_y2;
    logic        out_valid2, out_ready2, out_ovf2, out_err2, busy2;
    logic [1:0]  out_tag2;

    // Instance with PASSES = 1
    logic        in_ready1, dp_src1, dp_load1, dp_ovf1, dp_err1;
    logic [7:0]  dp_x1;
    logic [2:0]  dp_n1;
    logic [31:0] dp_y1, out_y1;
    logic        out_valid1, out_ovf1, out_err1, busy1;
    logic        out_ready1 = 1'b1;
    logic [1:0]  out_tag1;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int stall_start = 0;
    int stall_len_v = 0;

    exp_t  sb2[$];
    exp_t  sb1[$];
    ctrl_t ctrl_q[$];

    maclaurin_controller #(.PASSES(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_last(in_last), .in_x(in_x), .in_n(in_n),
        .dp_src(dp_src2), .dp_load(dp_load2), .dp_x(dp_x2), .dp_n(dp_n2),
        .dp_y(dp_y2), .dp_overflow(dp_ovf2), .dp_error(dp_err2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_y(out_y2),
        .out_tag(out_tag2), .out_overflow(out_ovf2), .out_error(out_err2),
        .busy(busy2)
    );

    maclaurin_controller #(.PASSES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_last(in_last), .in_x(in_x), .in_n(in_n),
        .dp_src(dp_src1), .dp_load(dp_load1), .dp_x(dp_x1), .dp_n(dp_n1),
        .dp_y(dp_y1), .dp_overflow(dp_ovf1), .dp_error(dp_err1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_y(out_y1),
        .out_tag(out_tag1), .out_overflow(out_ovf1), .out_error(out_err1),
        .busy(busy1)
    );

    // Datapath stand-in: 4-register ring. A new operand enters as {n,x};
    // every feedback trip adds 0x10000, so Y encodes operand and trip count.
    logic [31:0] r2 [4];
    logic [31:0] r1 [4];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r2[i] <= '0;
                r1[i] <= '0;
            end
        end else begin
            if (dp_load2) begin
                r2[0] <= dp_src2 ? (r2[3] + 32'h10000) : {21'b0, dp_n2, dp_x2};
                r2[1] <= r2[0];
                r2[2] <= r2[1];
                r2[3] <= r2[2];
            end
            if (dp_load1) begin
                r1[0] <= dp_src1 ? (r1[3] + 32'h10000) : {21'b0, dp_n1, dp_x1};
                r1[1] <= r1[0];
                r1[2] <= r1[1];
                r1[3] <= r1[2];
            end
        end
    end

    assign dp_y2   = r2[3];
    assign dp_ovf2 = r2[3][10];
    assign dp_err2 = (dp_x2 == 8'hEE);
    assign dp_y1   = r1[3];
    assign dp_ovf1 = r1[3][10];
    assign dp_err1 = (dp_x1 == 8'hEE);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] sig_val(input int id);
        case (id)
            0:       return 32'(dp_src2);
            1:       return 32'(dp_load2);
            2:       return 32'(busy2);
            3:       return 32'(dp_x2);
            4:       return 32'(in_ready2);
            5:       return 32'(out_valid2);
            6:       return 32'(busy1);
            7:       return 32'(in_ready1);
            default: return 32'hDEAD;
        endcase
    endfunction

    function automatic string sig_name(input int id);
        case (id)
            0:       return "dp_src";
            1:       return "dp_load";
            2:       return "busy";
            3:       return "dp_x";
            4:       return "in_ready";
            5:       return "out_valid";
            6:       return "busy_p1";
            7:       return "in_ready_p1";
            default: return "unknown";
        endcase
    endfunction

    task automatic cexp(input int c, input int id, input logic [31:0] v);
        ctrl_t e;
        e.cyc = c;
        e.id  = id;
        e.val = v;
        ctrl_q.push_back(e);
    endtask

    task automatic check_out(input int d, input logic v, input logic r,
                             input logic [1:0] tag, input logic [31:0] y,
                             input logic ovf, input logic err, input logic load);
        exp_t  e;
        string p;
        p = (d == 2) ? "p2" : "p1";
        if (!v || rst) return;
        if ((d == 2) ? (sb2.size() == 0) : (sb1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected_output at cycle %0d: got tag %0d, expected no output",
                     p, cyc, tag);
            return;
        end
        e = (d == 2) ? sb2[0] : sb1[0];
        chk({p, "_tag"}, 32'(tag), 32'(e.tag));
        chk({p, "_y"}, y, e.y);
        if (r) begin
            chk({p, "_overflow"}, 32'(ovf), 32'(e.ovf));
            chk({p, "_error"}, 32'(err), 32'(e.err));
            chk({p, "_out_cycle"}, 32'(cyc), 32'(e.cyc));
            if (d == 2) void'(sb2.pop_front());
            else        void'(sb1.pop_front());
        end else begin
            chk({p, "_stall_dp_load"}, 32'(load), 32'd0);
        end
    endtask

    // Monitor: outputs and scheduled control expectations, sampled mid-cycle.
    always @(negedge clk) begin
        check_out(2, out_valid2, out_ready2, out_tag2, out_y2, out_ovf2, out_err2, dp_load2);
        check_out(1, out_valid1, out_ready1, out_tag1, out_y1, out_ovf1, out_err1, dp_load1);
        while (ctrl_q.size() > 0 && ctrl_q[0].cyc <= cyc) begin
            if (ctrl_q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL ctrl_missed %s: scheduled cycle %0d, now %0d",
                         sig_name(ctrl_q[0].id), ctrl_q[0].cyc, cyc);
            end else begin
                chk(sig_name(ctrl_q[0].id), sig_val(ctrl_q[0].id), ctrl_q[0].val);
            end
            void'(ctrl_q.pop_front());
        end
    end

    initial begin
        out_ready2 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready2 = !(stall_len_v > 0 && cyc >= stall_start &&
                           cyc < stall_start + stall_len_v);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy2 || busy1) && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy still %0d/%0d, expected 0", busy2, busy1);
        end
    endtask

    // One batch. xs/ns/gaps packed per slot; gaps = idle cycles before each operand.
    task automatic run_batch(input int nops, input logic [31:0] xs_p, input logic [11:0] ns_p,
                             input logic [15:0] gaps_p, input int stall, input bit rst_mid);
        int fill_end, base2, base1, end2, r_cyc;
        exp_t e;
        logic [7:0] x;
        logic [2:0] n;
        wait_idle();
        for (int i = 0; i < nops; i++) begin
            for (int g = 0; g < int'(gaps_p[i*4 +: 4]); g++) begin
                in_valid = 1'b0;
                cexp(cyc, 1, 32'd0);
                step();
            end
            in_valid = 1'b1;
            in_x     = xs_p[i*8 +: 8];
            in_n     = ns_p[i*3 +: 3];
            in_last  = (nops < 4) && (i == nops - 1);
            cexp(cyc, 1, 32'd1);
            cexp(cyc, 0, 32'd0);
            cexp(cyc, 4, 32'd1);
            step();
        end
        in_last = 1'b0;
        // Offer junk during padding: it must neither be taken nor reach dp_x.
        for (int p = nops; p < 4; p++) begin
            in_valid = 1'b1;
            in_x     = 8'h77;
            in_n     = 3'd7;
            cexp(cyc, 3, 32'd0);
            cexp(cyc, 1, 32'd1);
            cexp(cyc, 4, 32'd0);
            step();
        end
        in_valid = 1'b0;
        in_x     = '0;
        in_n     = '0;
        fill_end = cyc - 1;
        base1    = fill_end + 1;
        base2    = fill_end + 5;
        if (rst_mid) begin
            r_cyc = fill_end + 2;
            x = xs_p[7:0];
            n = ns_p[2:0];
            e.tag = 0; e.y = {21'b0, n, x}; e.ovf = n[2]; e.err = (x == 8'hEE); e.cyc = base1;
            sb1.push_back(e);
            cexp(r_cyc + 1, 2, 32'd0);
            cexp(r_cyc + 1, 5, 32'd0);
            cexp(r_cyc + 1, 4, 32'd1);
            while (cyc < r_cyc) step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            return;
        end
        for (int k = 0; k < nops; k++) begin
            x = xs_p[k*8 +: 8];
            n = ns_p[k*3 +: 3];
            e.tag = k; e.y = {21'b0, n, x} + 32'h10000; e.ovf = n[2]; e.err = (x == 8'hEE);
            e.cyc = base2 + k + ((k >= 1) ? stall : 0);
            sb2.push_back(e);
            e.y = {21'b0, n, x};
            e.cyc = base1 + k;
            sb1.push_back(e);
        end
        if (stall > 0) begin
            stall_start = base2 + 1;
            stall_len_v = stall;
        end
        end2 = base2 + 4 + stall;
        for (int c = fill_end + 1; c <= fill_end + 4; c++) cexp(c, 0, 32'd1);
        cexp(base2, 6, 32'd0);
        cexp(base2, 0, 32'd1);
        for (int k = nops; k < 4; k++) cexp(base2 + k, 5, 32'd0);
        cexp(end2 - 1, 2, 32'd1);
        cexp(end2, 2, 32'd0);
        cexp(end2, 4, 32'd1);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_x = '0;
        in_n = '0;
        repeat (3) step();
        rst = 1'b0;
        cexp(cyc, 2, 32'd0);
        cexp(cyc, 5, 32'd0);
        cexp(cyc, 4, 32'd1);
        cexp(cyc, 1, 32'd0);
        cexp(cyc, 0, 32'd0);
        cexp(cyc, 3, 32'd0);
        cexp(cyc, 6, 32'd0);
        cexp(cyc, 7, 32'd1);
        step();

        // full batch, no stalls
        run_batch(4, 32'h44332211, {3'd4, 3'd3, 3'd2, 3'd1}, 16'h0000, 0, 1'b0);
        // early close on the 2nd operand
        run_batch(2, 32'h0000C35A, {3'd0, 3'd0, 3'd7, 3'd5}, 16'h0000, 0, 1'b0);
        // output backpressure on tag 1 for 3 cycles
        run_batch(4, 32'h7FFE8001, {3'd5, 3'd6, 3'd7, 3'd0}, 16'h0000, 3, 1'b0);
        // input gaps: operands at relative cycles 0, 3, 4, 7
        run_batch(4, 32'h9C8B7A69, {3'd2, 3'd6, 3'd1, 3'd3}, 16'h2020, 0, 1'b0);
        // error flag on slot 2 only
        run_batch(4, 32'h30EE2010, {3'd1, 3'd2, 3'd3, 3'd4}, 16'h0000, 0, 1'b0);
        // reset during ITER, then a clean full batch
        run_batch(4, 32'hDDCCBBAA, {3'd1, 3'd2, 3'd3, 3'd4}, 16'h0000, 0, 1'b1);
        run_batch(4, 32'h04030201, {3'd0, 3'd7, 3'd0, 3'd7}, 16'h0000, 0, 1'b0);

        t = 0;
        while ((sb2.size() > 0 || sb1.size() > 0 || ctrl_q.size() > 0) && t < 200) begin
            step();
            t++;
        end
        if (sb2.size() > 0 || sb1.size() > 0 || ctrl_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: pending p2=%0d p1=%0d ctrl=%0d, expected 0/0/0",
                     sb2.size(), sb1.size(), ctrl_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
